// File: rtl/svo_tmds_dec_pkg.sv
// rtl/svo_tmds_dec_pkg.sv - shared TMDS control tokens, token lookup and aligner state codes
//
// Purpose: the single source for the four TMDS control tokens and the
// token -> ctrl mapping, used by both the encoder and the decoder.
// Also holds the aligner FSM state codes.
// Ports: none (package).

package svo_tmds_dec_pkg;

  // Control tokens, written as they appear on the aligned word a[9:0].
  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  // Aligner FSM states.
  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Returns {hit, ctrl[1:0]}; hit=0 means the word is not a control token.
  function automatic logic [2:0] token_lookup(input logic [9:0] a);
    case (a)
      TOKEN_C00: return 3'b100;
      TOKEN_C01: return 3'b101;
      TOKEN_C10: return 3'b110;
      TOKEN_C11: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/svo_tmds_sym_dec.sv
// rtl/svo_tmds_sym_dec.sv - combinational TMDS symbol decoder for one aligned 10-bit word
//
// Purpose: classifies an aligned word as control token or data symbol and
// undoes the TMDS transition-minimising encoding.
// Ports:
//   a        in   10  aligned symbol, bit 0 first on the wire
//   is_ctrl  out   1  a is one of the four control tokens
//   ctrl     out   2  control value (0 when not a token)
//   data     out   8  decoded byte (meaningful only when is_ctrl=0)

module svo_tmds_sym_dec
  import svo_tmds_dec_pkg::*;
(
  input  logic [9:0] a,
  output logic       is_ctrl,
  output logic [1:0] ctrl,
  output logic [7:0] data
);

  logic [2:0] tok;
  logic [7:0] t;

  always_comb begin
    tok  = token_lookup(a);
    // a[9] marks a DC-balancing inversion of the payload bits.
    t    = a[9] ? ~a[7:0] : a[7:0];
    data = '0;
    data[0] = t[0];
    // a[8] selects whether the encoder chained with XOR or XNOR.
    for (int i = 1; i < 8; i++) begin
      data[i] = a[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
  end

  assign is_ctrl = tok[2];
  assign ctrl    = tok[1:0];

endmodule

// File: rtl/svo_tmds_dec.sv
// rtl/svo_tmds_dec.sv - TMDS word aligner and symbol decoder, one instance per channel
//
// Purpose: takes raw 10-bit deserializer words of unknown phase, finds the
// symbol boundary from runs of control tokens during blanking, decodes each
// aligned symbol and drops lock when blanking stops appearing.
// Ports:
//   clk         in   1  pixel clock
//   reset       in   1  asynchronous active-high reset
//   din_valid   in   1  din carries a new raw word
//   din         in  10  raw bits, bit 0 received first
//   dout_valid  out  1  decoded symbol valid (only while locked)
//   dout_de     out  1  1 = data symbol, 0 = control token
//   dout_ctrl   out  2  control value (0 for data symbols)
//   dout_data   out  8  decoded byte (0 for control tokens)
//   locked      out  1  aligner is locked
//   offset      out  4  current bit-slip offset, 0..9
// Pipeline: capture (cur/prev) -> align register -> FSM + decode register,
// so a word sampled with din_valid produces dout_valid three edges later.

module svo_tmds_dec
  import svo_tmds_dec_pkg::*;
#(
  parameter int LOCK_COUNT   = 16,
  parameter int MAX_DATA_RUN = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din_valid,
  input  logic [9:0] din,
  output logic       dout_valid,
  output logic       dout_de,
  output logic [1:0] dout_ctrl,
  output logic [7:0] dout_data,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int RW = $clog2(MAX_DATA_RUN + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [RW-1:0] RUN_LAST   = RW'(MAX_DATA_RUN - 1);

  logic [9:0]    cur, prev;
  logic          v1;
  logic [9:0]    a_reg;
  logic          v2;
  logic [0:0]    state;
  logic [MW-1:0] match_cnt;
  logic [RW-1:0] run_cnt;

  logic [19:0]   win;
  logic [9:0]    a_sel;
  logic          is_ctrl;
  logic [1:0]    ctrl;
  logic [7:0]    data;
  logic          lock_now, unlock_now, slip, emit;

  // prev holds the earlier word, so its bits come first in the window.
  assign win   = {cur, prev};
  assign a_sel = 10'(win >> offset);

  svo_tmds_sym_dec u_sym_dec (
    .a       (a_reg),
    .is_ctrl (is_ctrl),
    .ctrl    (ctrl),
    .data    (data)
  );

  always_comb begin
    lock_now   = 1'b0;
    unlock_now = 1'b0;
    slip       = 1'b0;
    if (v2) begin
      if (state == ST_SEARCH) begin
        if (is_ctrl) lock_now = (match_cnt == MATCH_LAST);
        else         slip     = 1'b1;
      end else if (!is_ctrl && run_cnt == RUN_LAST) begin
        unlock_now = 1'b1;
        slip       = 1'b1;
      end
    end
  end

  // The lock-completing symbol is emitted; the lock-losing symbol is not.
  assign emit   = v2 && (((state == ST_LOCKED) && !unlock_now) || lock_now);
  assign locked = (state == ST_LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur        <= '0;
      prev       <= '0;
      v1         <= 1'b0;
      a_reg      <= '0;
      v2         <= 1'b0;
      state      <= ST_SEARCH;
      match_cnt  <= '0;
      run_cnt    <= '0;
      offset     <= '0;
      dout_valid <= 1'b0;
      dout_de    <= 1'b0;
      dout_ctrl  <= '0;
      dout_data  <= '0;
    end else begin
      v1 <= din_valid;
      if (din_valid) begin
        prev <= cur;
        cur  <= din;
      end

      // A word aligned with the old offset is dropped when the offset moves.
      v2 <= v1 && !slip;
      if (v1) a_reg <= a_sel;

      if (slip) offset <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;

      if (v2) begin
        if (state == ST_SEARCH) begin
          if (!is_ctrl) begin
            match_cnt <= '0;
          end else if (lock_now) begin
            state     <= ST_LOCKED;
            match_cnt <= '0;
            run_cnt   <= '0;
          end else begin
            match_cnt <= match_cnt + MW'(1);
          end
        end else begin
          if (is_ctrl) begin
            run_cnt <= '0;
          end else if (unlock_now) begin
            state     <= ST_SEARCH;
            match_cnt <= '0;
            run_cnt   <= '0;
          end else begin
            run_cnt <= run_cnt + RW'(1);
          end
        end
      end

      dout_valid <= emit;
      if (emit) begin
        dout_de   <= !is_ctrl;
        dout_ctrl <= is_ctrl ? ctrl : 2'b00;
        dout_data <= is_ctrl ? 8'h00 : data;
      end
    end
  end

endmodule
